// File: rtl/cyclic_lock_pkg.sv
// Shared types and constants for the cyclic-lock key/evaluation controller.
// FSM state enum, c17 family widths and settle-counter width helper.
package cyclic_lock_pkg;

  localparam int C17_KEY_W = 2;
  localparam int C17_IN_W  = 5;
  localparam int C17_OUT_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    SETTLE,
    CAPTURE
  } state_t;

  // Counter only needs to hold n-1, never n.
  function automatic int cnt_w(input int n);
    return (n < 3) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cyclic_key_shadow.sv
// Serial key shadow register plus committed active key and key_valid flag.
// Shift and commit may coincide; commit takes the pre-shift shadow.
module cyclic_key_shadow
  import cyclic_lock_pkg::*;
#(
  parameter int KEY_W = C17_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sin,
  input  logic             key_shift,
  input  logic             commit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid
);

  logic [KEY_W-1:0] shadow;
  logic [KEY_W-1:0] shadow_nxt;

  generate
    if (KEY_W == 1) begin : g_one
      assign shadow_nxt = key_sin;
    end else begin : g_many
      assign shadow_nxt = {shadow[KEY_W-2:0], key_sin};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
    end else begin
      if (key_shift) shadow <= shadow_nxt;
      if (commit) begin
        key_out   <= shadow;
        key_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cyclic_key_eval_ctrl.sv
// Key loader and settle/capture sequencer for cyclic-locked combinational cores.
// Optional oscillation flag built only with CYCLIC_OSC_DETECT_EN defined.
module cyclic_key_eval_ctrl
  import cyclic_lock_pkg::*;
#(
  parameter int KEY_W      = C17_KEY_W,
  parameter int IN_W       = C17_IN_W,
  parameter int OUT_W      = C17_OUT_W,
  parameter int SETTLE_CYC = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sin,
  input  logic             key_shift,
  input  logic             key_commit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  core_in,
  input  logic [OUT_W-1:0] core_out,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             osc_err
);

  localparam int CW = cnt_w(SETTLE_CYC);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);

  state_t          state;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic            commit_ok;
  logic            accept;
  logic            cnt_zero;
  logic            last_settle;

  assign commit_ok   = key_commit &
                       ((state == IDLE) | (state == READY));
  assign accept      = (state == READY) & in_valid;
  assign cnt_zero    = (cnt == '0);
  assign last_settle = (state == SETTLE) & cnt_zero;
  assign in_ready    = (state == READY);
  assign out_valid   = (state == CAPTURE);

  cyclic_key_shadow #(
    .KEY_W(KEY_W)
  ) u_shadow (
    .clk      (clk),
    .rst      (rst),
    .key_sin  (key_sin),
    .key_shift(key_shift),
    .commit   (commit_ok),
    .key_out  (key_out),
    .key_valid(key_valid)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (commit_ok) nxt = READY;
      READY:   if (in_valid) nxt = SETTLE;
      SETTLE:  if (cnt_zero) nxt = CAPTURE;
      CAPTURE: nxt = READY;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      core_in  <= '0;
      out_data <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        core_in <= in_data;
        cnt     <= CNT_LOAD;
      end else if ((state == SETTLE) && !cnt_zero) begin
        cnt <= cnt - 1'b1;
      end
      // Sampled at the end of the last settle cycle so it is valid with out_valid.
      if (last_settle) out_data <= core_out;
    end
  end

`ifdef CYCLIC_OSC_DETECT_EN
  logic osc_q;

  // A stable core still shows the settled sample while capturing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      osc_q <= 1'b0;
    end else if (accept) begin
      osc_q <= 1'b0;
    end else if ((state == CAPTURE) && (core_out != out_data)) begin
      osc_q <= 1'b1;
    end
  end

  assign osc_err = osc_q;
`else
  assign osc_err = 1'b0;
`endif

endmodule

// File: tb/tb_cyclic_key_eval_ctrl.sv
// Scoreboard bench for cyclic_key_eval_ctrl driving a c17 core model.
// Key 2'b11 makes the model oscillate to exercise CYCLIC_OSC_DETECT_EN.
module tb_cyclic_key_eval_ctrl;

  localparam int S   = 4;
  localparam int PER = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_sin = 1'b0;
  logic       key_shift = 1'b0;
  logic       key_commit = 1'b0;
  logic [1:0] key_out;
  logic       key_valid;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [4:0] in_data = '0;
  logic [4:0] core_in;
  logic [1:0] core_out;
  logic       out_valid;
  logic [1:0] out_data;
  logic       osc_err;

  typedef struct {
    logic [1:0] d;
    bit         chk;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic tog = 1'b0;

  cyclic_key_eval_ctrl #(
    .KEY_W(2), .IN_W(5), .OUT_W(2), .SETTLE_CYC(S)
  ) dut (
    .clk(clk), .rst(rst),
    .key_sin(key_sin), .key_shift(key_shift),
    .key_commit(key_commit),
    .key_out(key_out), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .core_in(core_in),
    .core_out(core_out), .out_valid(out_valid),
    .out_data(out_data), .osc_err(osc_err)
  );

  always #(PER/2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) tog <= ~tog;

  // c17: core_in = {N1,N2,N3,N6,N7}, core_out = {N22,N23}
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n10, n11, n16, n19;
    n10 = ~(v[4] & v[2]);
    n11 = ~(v[2] & v[1]);
    n16 = ~(v[3] & n11);
    n19 = ~(n11 & v[0]);
    return {~(n10 & n16), ~(n16 & n19)};
  endfunction

  always_comb begin
    core_out = c17(core_in);
    if (key_out == 2'b11) core_out = core_out ^ {tog, tog};
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid cyc=%0d", cyc);
      end else begin
        e = q.pop_front();
        check("out_cycle", cyc, e.cyc);
        if (e.chk) check("out_data", {30'd0, out_data}, {30'd0, e.d});
        check("in_ready_capture", {31'd0, in_ready}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    key_sin = b;
    key_shift = 1'b1;
    step();
    key_shift = 1'b0;
  endtask

  task automatic commit();
    key_commit = 1'b1;
    step();
    key_commit = 1'b0;
  endtask

  task automatic load_key(input logic [1:0] k);
    shift_bit(k[1]);
    shift_bit(k[0]);
    commit();
    check("key_load", {30'd0, key_out}, {30'd0, k});
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!in_ready && g < 100) begin
      step();
      g++;
    end
    if (!in_ready) check("wait_ready_timeout", 0, 1);
  endtask

  // Holds in_valid high until n requests are accepted.
  task automatic issue(input logic [4:0] d, input logic [1:0] x,
                       input bit chk, input bit push, input int n);
    int got = 0;
    int g = 0;
    exp_t it;
    in_data = d;
    in_valid = 1'b1;
    while (got < n && g < 200) begin
      if (in_ready) begin
        it.d = x;
        it.chk = chk;
        it.cyc = cyc + 1 + S;
        if (push) q.push_back(it);
        got++;
      end
      step();
      g++;
    end
    in_valid = 1'b0;
    if (got < n) check("issue_timeout", got, n);
    check("core_in", {27'd0, core_in}, {27'd0, d});
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    step();
    check("rst_key_out", {30'd0, key_out}, 0);
    check("rst_key_valid", {31'd0, key_valid}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_out_data", {30'd0, out_data}, 0);
    check("rst_core_in", {27'd0, core_in}, 0);
    check("rst_osc_err", {31'd0, osc_err}, 0);

    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) step();
    in_valid = 1'b0;
    check("idle_in_ready", {31'd0, in_ready}, 0);

    shift_bit(1'b1);
    check("shift1_key_out", {30'd0, key_out}, 0);
    shift_bit(1'b0);
    check("shift2_key_out", {30'd0, key_out}, 0);
    commit();
    check("commit_key_out", {30'd0, key_out}, 2);
    check("commit_key_valid", {31'd0, key_valid}, 1);
    check("commit_ready", {31'd0, in_ready}, 1);

    load_key(2'b00);
    issue(5'b11111, 2'b10, 1'b1, 1'b1, 1);
    for (int k = 0; k <= S; k++) check("settle_not_ready", {31'd0, in_ready}, 0);
    for (int k = 0; k <= S; k++) if (k < S + 1) step();
    check("ready_again", {31'd0, in_ready}, 1);

    issue(5'b00000, 2'b00, 1'b1, 1'b1, 1);
    wait_ready();
    issue(5'b10101, 2'b11, 1'b1, 1'b1, 3);
    wait_ready();
    issue(5'b01010, 2'b11, 1'b1, 1'b1, 1);
    wait_ready();
    for (int k = 0; k < 4; k++) step();
    check("out_data_hold", {30'd0, out_data}, 3);
    issue(5'b00111, 2'b00, 1'b1, 1'b1, 1);

    shift_bit(1'b1);
    shift_bit(1'b1);
    commit();
    check("commit_blocked", {30'd0, key_out}, 0);
    wait_ready();
    commit();
    check("commit_after", {30'd0, key_out}, 3);

    issue(5'b10101, 2'b00, 1'b0, 1'b1, 1);
    wait_ready();
`ifdef CYCLIC_OSC_DETECT_EN
    check("osc_set", {31'd0, osc_err}, 1);
`else
    check("osc_tied", {31'd0, osc_err}, 0);
`endif
    issue(5'b10101, 2'b00, 1'b0, 1'b1, 1);
    check("osc_clear", {31'd0, osc_err}, 0);
    wait_ready();

    load_key(2'b00);
    issue(5'b11111, 2'b10, 1'b1, 1'b0, 1);
    step();
    rst = 1'b1;
    #1;
    check("midrst_key_valid", {31'd0, key_valid}, 0);
    check("midrst_key_out", {30'd0, key_out}, 0);
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    step();
    step();
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < S + 4; i++) step();
    in_valid = 1'b0;
    check("post_rst_in_ready", {31'd0, in_ready}, 0);
    load_key(2'b00);
    issue(5'b10101, 2'b11, 1'b1, 1'b1, 1);
    wait_ready();

    for (int i = 0; i < 4; i++) step();
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
